motor_drive_sequencer: RTL

MOTOR_DRIVE_SEQUENCER -- requirements
Module: motor_drive_sequencer

---
 rtl/motor_drive_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/motor_drive_sequencer.sv
// Two-sided H-bridge drive sequencer with reversal dead time, PWM on the run
// states, a pump relay with post-request hold and a pulsed buzzer.
module motor_drive_sequencer #(
  parameter logic [7:0] PWM_DUTY  = 8'd192,
  parameter int         DEAD_CYC  = 16,
  parameter int         PUMP_HOLD = 1000,
  parameter int         BEEP_HALF = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic leftforward,
  input  logic leftbackwards,
  input  logic rightforward,
  input  logic rightbackwards,
  input  logic Buzzer,
  input  logic pump,
  output logic l_in1,
  output logic l_in2,
  output logic r_in1,
  output logic r_in2,
  output logic pump_out,
  output logic buzzer_out
);

  localparam logic [1:0] ST_COAST = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  localparam logic [1:0] CMD_COAST = 2'd0;
  localparam logic [1:0] CMD_FWD   = 2'd1;
  localparam logic [1:0] CMD_REV   = 2'd2;
  localparam logic [1:0] CMD_BRAKE = 2'd3;

  localparam logic [7:0]  DEAD_LOAD = 8'(DEAD_CYC - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(PUMP_HOLD);
  localparam logic [15:0] BEEP_TOP  = 16'(BEEP_HALF);

  // cmd_q bit order: {lf, lb, rf, rb, buzzer, pump}
  logic [5:0]       cmd_q;
  logic [7:0]       pwm_cnt_q;
  logic             pwm;
  logic [1:0][1:0]  side_raw;
  logic [1:0][1:0]  new_cmd;
  logic [1:0][1:0]  state_q, state_d;
  logic [1:0][1:0]  act_q, act_d;
  logic [1:0][7:0]  dead_q, dead_d;
  logic [1:0][1:0]  drive_q, drive_d;
  logic [15:0]      hold_q, hold_d;
  logic             pump_q, pump_d;
  logic [15:0]      beep_q, beep_d;
  logic             buz_q, buz_d;

  function automatic logic [1:0] decode(input logic [1:0] fb);
    case (fb)
      2'b10:   decode = CMD_FWD;
      2'b01:   decode = CMD_REV;
      2'b11:   decode = CMD_BRAKE;
      default: decode = CMD_COAST;
    endcase
  endfunction

  assign pwm      = (pwm_cnt_q < PWM_DUTY);
  assign side_raw = {cmd_q[3:2], cmd_q[5:4]};

  // Index 0 is the left side, index 1 the right side.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    dead_d  = dead_q;
    drive_d = '0;
    new_cmd = '0;
    for (int s = 0; s < 2; s++) begin
      new_cmd[s] = decode(side_raw[s]);
      if (state_q[s] == ST_DEAD) begin
        // The command sampled at expiry is taken as-is, even a return to the old direction.
        if (dead_q[s] == 8'd0) begin
          act_d[s]   = new_cmd[s];
          state_d[s] = (new_cmd[s] == CMD_COAST) ? ST_COAST : ST_RUN;
        end else begin
          dead_d[s] = dead_q[s] - 8'd1;
        end
      end else if (new_cmd[s] != act_q[s]) begin
        if (new_cmd[s] == CMD_COAST) begin
          act_d[s]   = CMD_COAST;
          state_d[s] = ST_COAST;
        end else if (act_q[s] == CMD_COAST || act_q[s] == CMD_BRAKE) begin
          act_d[s]   = new_cmd[s];
          state_d[s] = ST_RUN;
        end else begin
          state_d[s] = ST_DEAD;
          dead_d[s]  = DEAD_LOAD;
        end
      end
      if (state_d[s] != ST_DEAD) begin
        case (act_d[s])
          CMD_FWD:   drive_d[s] = {pwm, 1'b0};
          CMD_REV:   drive_d[s] = {1'b0, pwm};
          CMD_BRAKE: drive_d[s] = 2'b11;
          default:   drive_d[s] = 2'b00;
        endcase
      end
    end
  end

  // Pump: a fall of the request is seen as pump_out high with no hold running.
  always_comb begin
    hold_d = hold_q;
    pump_d = 1'b0;
    if (cmd_q[0]) begin
      hold_d = '0;
      pump_d = 1'b1;
    end else if (pump_q && hold_q == 16'd0) begin
      hold_d = HOLD_LOAD;
      pump_d = 1'b1;
    end else if (hold_q != 16'd0) begin
      hold_d = hold_q - 16'd1;
      pump_d = (hold_q != 16'd1);
    end
  end

  // Beep counter runs 1..BEEP_HALF while held; zero marks a fresh request.
  always_comb begin
    beep_d = '0;
    buz_d  = 1'b0;
    if (cmd_q[1]) begin
      if (beep_q == 16'd0) begin
        beep_d = 16'd1;
        buz_d  = 1'b1;
      end else if (beep_q == BEEP_TOP) begin
        beep_d = 16'd1;
        buz_d  = ~buz_q;
      end else begin
        beep_d = beep_q + 16'd1;
        buz_d  = buz_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= '0;
      pwm_cnt_q <= '0;
      state_q   <= {ST_COAST, ST_COAST};
      act_q     <= {CMD_COAST, CMD_COAST};
      dead_q    <= '0;
      drive_q   <= '0;
      hold_q    <= '0;
      pump_q    <= 1'b0;
      beep_q    <= '0;
      buz_q     <= 1'b0;
    end else begin
      cmd_q     <= {leftforward, leftbackwards, rightforward, rightbackwards, Buzzer, pump};
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      state_q   <= state_d;
      act_q     <= act_d;
      dead_q    <= dead_d;
      drive_q   <= drive_d;
      hold_q    <= hold_d;
      pump_q    <= pump_d;
      beep_q    <= beep_d;
      buz_q     <= buz_d;
    end
  end

  assign l_in1      = drive_q[0][1];
  assign l_in2      = drive_q[0][0];
  assign r_in1      = drive_q[1][1];
  assign r_in2      = drive_q[1][0];
  assign pump_out   = pump_q;
  assign buzzer_out = buz_q;

endmodule
